// File: rtl/program_loader.sv
// rtl/program_loader.sv - host command-stream loader and run controller for the RISC-V Lite datapath
module program_loader #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_DATA,
    output logic        TB_LOAD_PROGRAM_CTRL,
    output logic [9:0]  TB_LOAD_PROGRAM_ADDR,
    output logic [31:0] TB_LOAD_PROGRAM_DATA,
    output logic        TB_LOAD_DATA_CTRL,
    output logic [9:0]  TB_LOAD_DATA_ADDR,
    output logic [31:0] TB_LOAD_DATA_DATA,
    output logic        CORE_RSTn,
    output logic        START,
    output logic        EN,
    input  logic        OK,
    output logic        RUN_DONE,
    output logic        RUN_TIMEOUT,
    output logic [31:0] CYCLES,
    output logic        ERR,
    output logic        BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_P, S_LOAD_D, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [10:0] rem_q, rem_d;
    logic        pctrl_q, pctrl_d, dctrl_q, dctrl_d;
    logic [9:0]  paddr_q, paddr_d, daddr_q, daddr_d;
    logic [31:0] pdata_q, pdata_d, ddata_q, ddata_d;
    logic        rstn_q, rstn_d, start_q, start_d, en_q, en_d;
    logic        done_q, done_d, tmo_q, tmo_d, err_q, err_d;
    logic [31:0] cycles_q, cycles_d;

    logic [1:0]  hdr_cmd;
    logic [9:0]  hdr_base;
    logic [10:0] hdr_cnt;
    logic        hdr_len_ok, hdr_bad, accept, timeout_hit;
    logic [31:0] cycles_inc;
    logic        hdr_unused;

    assign hdr_cmd    = IN_DATA[31:30];
    assign hdr_base   = IN_DATA[29:20];
    assign hdr_cnt    = IN_DATA[10:0];
    assign hdr_unused = ^IN_DATA[19:11];
    assign hdr_len_ok = (hdr_cnt != 11'd0) && (hdr_cnt <= 11'd1024);
    // RUN ignores the count field; only load commands need a legal length
    assign hdr_bad    = (hdr_cmd == 2'b11) || ((hdr_cmd != 2'b10) && !hdr_len_ok);

    assign IN_READY    = (state_q != S_RUN);
    assign BUSY        = (state_q != S_IDLE);
    assign accept      = IN_VALID && IN_READY;
    assign cycles_inc  = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cycles_inc == TIMEOUT_CYCLES);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            pctrl_q  <= 1'b0;
            paddr_q  <= '0;
            pdata_q  <= '0;
            dctrl_q  <= 1'b0;
            daddr_q  <= '0;
            ddata_q  <= '0;
            rstn_q   <= 1'b0;
            start_q  <= 1'b0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            pctrl_q  <= pctrl_d;
            paddr_q  <= paddr_d;
            pdata_q  <= pdata_d;
            dctrl_q  <= dctrl_d;
            daddr_q  <= daddr_d;
            ddata_q  <= ddata_d;
            rstn_q   <= rstn_d;
            start_q  <= start_d;
            en_q     <= en_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !hdr_bad) begin
                    case (hdr_cmd)
                        2'b00:   state_d = S_LOAD_P;
                        2'b01:   state_d = S_LOAD_D;
                        default: state_d = S_RUN;
                    endcase
                end
            end
            S_LOAD_P, S_LOAD_D: begin
                if (accept && rem_q == 11'd1) state_d = S_IDLE;
            end
            S_RUN: begin
                if (OK || timeout_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        rem_d    = rem_q;
        pctrl_d  = 1'b0;
        paddr_d  = paddr_q;
        pdata_d  = pdata_q;
        dctrl_d  = 1'b0;
        daddr_d  = daddr_q;
        ddata_d  = ddata_q;
        rstn_d   = rstn_q;
        start_d  = start_q;
        en_d     = en_q;
        done_d   = 1'b0;
        tmo_d    = 1'b0;
        err_d    = 1'b0;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hdr_bad) begin
                        err_d = 1'b1;
                    end else if (hdr_cmd == 2'b10) begin
                        cycles_d = '0;
                        rstn_d   = 1'b1;
                        start_d  = 1'b1;
                        en_d     = 1'b1;
                    end else begin
                        addr_d = hdr_base;
                        rem_d  = hdr_cnt;
                        rstn_d = 1'b0;
                    end
                end
            end
            S_LOAD_P, S_LOAD_D: begin
                if (accept) begin
                    if (state_q == S_LOAD_P) begin
                        pctrl_d = 1'b1;
                        paddr_d = addr_q;
                        pdata_d = IN_DATA;
                    end else begin
                        dctrl_d = 1'b1;
                        daddr_d = addr_q;
                        ddata_d = IN_DATA;
                    end
                    addr_d = addr_q + 10'd1;
                    rem_d  = rem_q - 11'd1;
                end
            end
            S_RUN: begin
                // the cycle in which OK is sampled still counts; OK beats a coincident timeout
                cycles_d = cycles_inc;
                if (OK) begin
                    done_d  = 1'b1;
                    start_d = 1'b0;
                    en_d    = 1'b0;
                end else if (timeout_hit) begin
                    tmo_d   = 1'b1;
                    start_d = 1'b0;
                    en_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign TB_LOAD_PROGRAM_CTRL = pctrl_q;
    assign TB_LOAD_PROGRAM_ADDR = paddr_q;
    assign TB_LOAD_PROGRAM_DATA = pdata_q;
    assign TB_LOAD_DATA_CTRL    = dctrl_q;
    assign TB_LOAD_DATA_ADDR    = daddr_q;
    assign TB_LOAD_DATA_DATA    = ddata_q;
    assign CORE_RSTn            = rstn_q;
    assign START                = start_q;
    assign EN                   = en_q;
    assign RUN_DONE             = done_q;
    assign RUN_TIMEOUT          = tmo_q;
    assign CYCLES               = cycles_q;
    assign ERR                  = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader with random command streams
module tb_program_loader;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, ok;
    logic [31:0] in_data;
    logic        pctrl, dctrl, core_rstn, start, en, run_done, run_tmo, err, busy;
    logic [9:0]  paddr, daddr;
    logic [31:0] pdata, ddata, cycles;

    program_loader #(.TIMEOUT_CYCLES(32'(TO))) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .TB_LOAD_PROGRAM_CTRL(pctrl), .TB_LOAD_PROGRAM_ADDR(paddr), .TB_LOAD_PROGRAM_DATA(pdata),
        .TB_LOAD_DATA_CTRL(dctrl), .TB_LOAD_DATA_ADDR(daddr), .TB_LOAD_DATA_DATA(ddata),
        .CORE_RSTn(core_rstn), .START(start), .EN(en), .OK(ok),
        .RUN_DONE(run_done), .RUN_TIMEOUT(run_tmo), .CYCLES(cycles), .ERR(err), .BUSY(busy)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_prog; logic [9:0] addr; logic [31:0] data;} wr_t;
    typedef struct {int kind; logic [31:0] cyc;} ev_t;  // kind: 0 ERR, 1 RUN_DONE, 2 RUN_TIMEOUT
    wr_t wr_q[$];
    ev_t ev_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    wr_t mw;
    ev_t me;
    int  mkind;
    always @(negedge clk) begin
        if (pctrl === 1'b1 || dctrl === 1'b1) begin
            chk("strobe_exclusive", {31'd0, pctrl & dctrl}, 32'd0);
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mw = wr_q.pop_front();
                chk("wr_is_prog", {31'd0, pctrl}, {31'd0, mw.is_prog});
                chk("wr_addr", {22'd0, pctrl ? paddr : daddr}, {22'd0, mw.addr});
                chk("wr_data", pctrl ? pdata : ddata, mw.data);
            end
        end
        if (err === 1'b1 || run_done === 1'b1 || run_tmo === 1'b1) begin
            chk("pulse_exclusive", 32'(err) + 32'(run_done) + 32'(run_tmo), 32'd1);
            mkind = err ? 0 : (run_done ? 1 : 2);
            if (ev_q.size() == 0) begin
                chk("unexpected_pulse", 32'(mkind), 32'hFFFF_FFFF);
            end else begin
                me = ev_q.pop_front();
                chk("pulse_kind", 32'(mkind), 32'(me.kind));
                if (me.kind != 0) begin
                    chk("run_cycles", cycles, me.cyc);
                    chk("start_low_at_end", {31'd0, start}, 32'd0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int  n   = 0;
        bit  acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        while (!acc && n < 100) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("handshake_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic check_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_pctrl", {31'd0, pctrl}, 32'd0);
        chk("rst_paddr", {22'd0, paddr}, 32'd0);
        chk("rst_pdata", pdata, 32'd0);
        chk("rst_dctrl", {31'd0, dctrl}, 32'd0);
        chk("rst_daddr", {22'd0, daddr}, 32'd0);
        chk("rst_ddata", ddata, 32'd0);
        chk("rst_core_rstn", {31'd0, core_rstn}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_run_done", {31'd0, run_done}, 32'd0);
        chk("rst_run_timeout", {31'd0, run_tmo}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_load(input bit prog, input logic [9:0] base, input int n,
                           input int gap_min, input int gap_max, input logic [8:0] junk);
        logic [31:0] d;
        send_word({prog ? 2'b00 : 2'b01, base, junk, 11'(n)});
        chk("load_core_rstn_low", {31'd0, core_rstn}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i > 0) idle($urandom_range(gap_max, gap_min));
            d = $urandom;
            wr_q.push_back('{prog, 10'((int'(base) + i) % 1024), d});
            send_word(d);
        end
        chk("load_busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_run(input int m);
        int steps;
        steps = (m <= TO) ? m : TO;
        ev_q.push_back('{(m <= TO) ? 1 : 2, 32'(steps)});
        send_word({2'b10, 30'($urandom)});
        chk("run_start", {31'd0, start}, 32'd1);
        chk("run_en", {31'd0, en}, 32'd1);
        chk("run_core_rstn", {31'd0, core_rstn}, 32'd1);
        chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i <= steps; i++) begin
            ok = (i == m);
            @(posedge clk); #1;
            ok = 1'b0;
        end
        chk("after_run_start", {31'd0, start}, 32'd0);
        chk("after_run_en", {31'd0, en}, 32'd0);
        chk("after_run_core_rstn", {31'd0, core_rstn}, 32'd1);
        chk("after_run_busy", {31'd0, busy}, 32'd0);
        chk("after_run_cycles", cycles, 32'(steps));
    endtask

    task automatic bad_header(input int variant);
        logic [1:0]  cmd;
        logic [10:0] n;
        cmd = 2'($urandom_range(1, 0));
        case (variant)
            0:       begin cmd = 2'b11; n = 11'($urandom); end
            1:       n = 11'd0;
            2:       n = 11'd1025;
            default: n = 11'($urandom_range(2047, 1025));
        endcase
        ev_q.push_back('{0, 32'd0});
        send_word({cmd, 10'($urandom), 9'($urandom), n});
        chk("bad_hdr_busy", {31'd0, busy}, 32'd0);
        chk("bad_hdr_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        idle(2);

        do_load(1'b1, 10'h3FE, 3, 0, 0, 9'd0);
        do_load(1'b0, 10'h010, 2, 1, 1, 9'($urandom));
        do_run(5);
        do_run(12);
        do_run(TO);
        for (int v = 0; v < 3; v++) bad_header(v);
        do_load(1'b1, 10'($urandom), 4, 0, 0, 9'($urandom));

        // abandon a load part-way through with a two-cycle reset
        send_word({2'b00, 10'h100, 9'd0, 11'd5});
        for (int i = 0; i < 2; i++) begin
            logic [31:0] d;
            d = $urandom;
            wr_q.push_back('{1'b1, 10'(10'h100 + i), d});
            send_word(d);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst = 1'b0;
        idle(1);
        do_run(3);

        do_load(1'b0, 10'($urandom), 1024, 0, 0, 9'($urandom));

        for (int k = 0; k < 30; k++) begin
            int r;
            r = $urandom_range(9, 0);
            if (r <= 3)      do_load(1'($urandom), 10'($urandom), $urandom_range(16, 1), 0, 2, 9'($urandom));
            else if (r <= 6) do_run($urandom_range(12, 1));
            else             bad_header($urandom_range(3, 0));
            idle($urandom_range(2, 0));
        end

        idle(5);
        chk("writes_outstanding", 32'(wr_q.size()), 32'd0);
        chk("events_outstanding", 32'(ev_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side loader and run controller for the RISC-V Lite datapath. It sits between a 32-bit valid/ready command stream from the testbench or debug host and the datapath's program/data load ports and START/OK handshake. It decodes header words and writes payload words into instruction or data memory one word per cycle. It then releases the core, runs it until OK or timeout, and reports the cycle count.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32'd1_000_000, abort RUN after this many cycles; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- IN_VALID  in  1  command/payload word valid.
- IN_READY  out  1  loader accepts the word; transfer happens when IN_VALID & IN_READY.
- IN_DATA  in  32  header or payload word.
- TB_LOAD_PROGRAM_CTRL  out  1  instruction-memory write strobe.
- TB_LOAD_PROGRAM_ADDR  out  10  instruction-memory word address.
- TB_LOAD_PROGRAM_DATA  out  32  instruction word.
- TB_LOAD_DATA_CTRL  out  1  data-memory write strobe.
- TB_LOAD_DATA_ADDR  out  10  data-memory word address.
- TB_LOAD_DATA_DATA  out  32  data word.
- CORE_RSTn  out  1  active-low reset for the datapath.
- START  out  1  datapath start.
- EN  out  1  datapath enable.
- OK  in  1  datapath completion flag.
- RUN_DONE  out  1  one-cycle pulse: run ended by OK.
- RUN_TIMEOUT  out  1  one-cycle pulse: run aborted by timeout.
- CYCLES  out  32  length of the last run.
- ERR  out  1  one-cycle pulse: bad header dropped.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Header format:
  - [31:30] cmd: 00 = LOAD_PROG, 01 = LOAD_DATA, 10 = RUN, 11 = reserved.
  - [29:20] base word address.
  - [10:0] count N.
  - All other bits are ignored.
- States: IDLE, LOAD_P, LOAD_D, RUN.
- IDLE: IN_READY = 1. On an accepted header:
  - LOAD_PROG or LOAD_DATA with 1 ≤ N ≤ 1024: latch addr = base and remaining = N, drive CORE_RSTn = 0, go to LOAD_P or LOAD_D.
  - RUN: clear CYCLES, drive CORE_RSTn = 1, START = 1, EN = 1, go to RUN.
  - cmd 11, N = 0, or N > 1024: pulse ERR, stay in IDLE, drop the word.
- LOAD_P / LOAD_D: IN_READY = 1.
  - Each accepted payload word is written to memory at the current addr; then addr increments mod 1024 (0x3FF wraps to 0x000) and remaining decrements.
  - When the last word is accepted, return to IDLE.
  - No header parsing happens during a load. The payload length is strictly N words.
- RUN: IN_READY = 0.
  - CYCLES increments each cycle, saturating at 0xFFFF_FFFF.
  - OK sampled high: pulse RUN_DONE, drop START and EN, go to IDLE.
  - Otherwise, CYCLES reaching TIMEOUT_CYCLES (when non-zero): pulse RUN_TIMEOUT, drop START and EN, go to IDLE.
  - OK and timeout in the same cycle: OK wins; RUN_DONE only.
- CORE_RSTn stays high in IDLE after a run, so results remain observable. It goes low only when the next load header is accepted.
- At most one write strobe is high in any cycle. The strobe is never high outside LOAD_P / LOAD_D write cycles.

## Timing
- Reset values: state IDLE; IN_READY = 1; all CTRL strobes, ADDR, and DATA outputs = 0; CORE_RSTn = 0; START = 0; EN = 0; RUN_DONE = 0; RUN_TIMEOUT = 0; ERR = 0; CYCLES = 0; BUSY = 0.
- RST asserted mid-load or mid-run returns to reset values on the next edge. Any partial load is abandoned, and in-flight strobes deassert at that edge.
- All outputs are registered except IN_READY and BUSY, which are decoded from state.
- Write latency: a payload accepted at edge k produces CTRL = 1 with its ADDR and DATA during cycle k+1, for exactly one cycle.
- Back-to-back writes:
  - IN_VALID held high gives one write per cycle.
  - An N-word load takes N+1 accepted beats (header + N payload words). IDLE is re-entered on the edge of the last beat.
- Run: a RUN header accepted at edge k gives START = EN = CORE_RSTn = 1 from cycle k+1.
  - CYCLES counts cycles with START = 1, including the cycle in which OK is sampled.
  - With OK sampled at edge k+m, CYCLES = m and RUN_DONE pulses in cycle k+m+1, while START = 0.
- ERR, RUN_DONE, and RUN_TIMEOUT are each high for exactly one cycle.

## Test plan
- Reset check: assert RST for 2 cycles mid-stream -> every output equals its reset value; IN_READY = 1.
- Program load with wrap: header 0x3FE0_0003 (LOAD_PROG, base 0x3FE, N = 3), payload A, B, C back-to-back -> program strobes on 3 consecutive cycles at addresses 0x3FE, 0x3FF, 0x000 with data A, B, C; data strobe stays 0; BUSY falls after C.
- Data load with stalls: LOAD_DATA, base 0x010, N = 2, IN_VALID toggling 1/0 -> exactly 2 data strobes at 0x010 and 0x011; no strobe in idle-valid cycles.
- Run to completion: RUN header, OK raised on the 5th START cycle -> CYCLES = 5, one RUN_DONE pulse, START = EN = 0 afterwards, CORE_RSTn = 1.
- Timeout: TIMEOUT_CYCLES = 8, OK held 0 -> RUN_TIMEOUT pulse, CYCLES = 8, no RUN_DONE. Repeat with OK rising exactly at cycle 8 -> RUN_DONE only.
- Bad headers: cmd 11; N = 0; N = 1025 -> ERR pulse each time, no strobes, state remains IDLE; a subsequent valid load still works.
